mem_bus_rr_arbiter: RTL

//  Two-master round-robin arbiter for the single merged memory bus. Master 0 is the CPU merged

---
 rtl/mem_bus_rr_arbiter_if.sv | 56 +++++
 rtl/mem_bus_rr_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_rr_arbiter_if.sv
// Signal bundle between the two bus masters, the round-robin arbiter and the
// single merged memory bus. The arbiter uses the slave modport; the
// environment (masters plus memory) uses the master modport.
interface mem_bus_rr_arbiter_if;
   // master 0: CPU merged port
   logic        m0_rd_i;
   logic        m0_wr_i;
   logic [31:0] m0_addr_i;
   logic [31:0] m0_data_i;
   logic [3:0]  m0_bsel_i;
   logic        m0_ready_o;
   logic [31:0] m0_data_o;
   logic        m0_err_o;

   // master 1: DMA / debug
   logic        m1_rd_i;
   logic        m1_wr_i;
   logic [31:0] m1_addr_i;
   logic [31:0] m1_data_i;
   logic [3:0]  m1_bsel_i;
   logic        m1_ready_o;
   logic [31:0] m1_data_o;
   logic        m1_err_o;

   // merged memory bus
   logic        mem_ready_i;
   logic [31:0] mem_data_i;
   logic        mem_rd_o;
   logic        mem_wr_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic [3:0]  mem_bsel_o;

   // current bus owner, one-hot
   logic [1:0]  grant_o;

   modport slave (
      input  m0_rd_i, m0_wr_i, m0_addr_i, m0_data_i, m0_bsel_i,
      output m0_ready_o, m0_data_o, m0_err_o,
      input  m1_rd_i, m1_wr_i, m1_addr_i, m1_data_i, m1_bsel_i,
      output m1_ready_o, m1_data_o, m1_err_o,
      input  mem_ready_i, mem_data_i,
      output mem_rd_o, mem_wr_o, mem_addr_o, mem_data_o, mem_bsel_o,
      output grant_o
   );

   modport master (
      output m0_rd_i, m0_wr_i, m0_addr_i, m0_data_i, m0_bsel_i,
      input  m0_ready_o, m0_data_o, m0_err_o,
      output m1_rd_i, m1_wr_i, m1_addr_i, m1_data_i, m1_bsel_i,
      input  m1_ready_o, m1_data_o, m1_err_o,
      output mem_ready_i, mem_data_i,
      input  mem_rd_o, mem_wr_o, mem_addr_o, mem_data_o, mem_bsel_o,
      input  grant_o
   );
endinterface

// File: rtl/mem_bus_rr_arbiter.sv
// Two-master round-robin arbiter for the merged memory bus. One transaction
// at a time: IDLE picks a master, BUSY holds the registered bus request until
// the memory answers or the timeout fires, RESP returns a one-cycle response
// to the owner. A request with both rd and wr set never reaches the bus and
// is answered with an error.
module mem_bus_rr_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   mem_bus_rr_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_e;

   // Counter only needs to reach TIMEOUT_CYCLES-1; with the timeout off it
   // just wraps and is never looked at.
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST =
      TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;   // index of the last granted master
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        grant_q, grant_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_bsel_q, mem_bsel_d;
   logic [1:0]        rsp_ready_q, rsp_ready_d;     // one-hot, only set in RESP
   logic              rsp_err_q, rsp_err_d;
   logic [31:0]       rsp_data_q, rsp_data_d;

   logic              req0, req1;
   logic              win;
   logic [1:0]        win_onehot;
   logic              sel_rd, sel_wr;
   logic [31:0]       sel_addr, sel_wdata;
   logic [3:0]        sel_bsel;
   logic              timeout_hit;

   assign req0 = bus.m0_rd_i | bus.m0_wr_i;
   assign req1 = bus.m1_rd_i | bus.m1_wr_i;

   // Winner of the current IDLE cycle; a tie goes to the master not granted last.
   always_comb begin
      win = 1'b0;
      if (req0 && req1) begin
         win = ~last_grant_q;
      end else if (req1) begin
         win = 1'b1;
      end
   end

   assign win_onehot = win ? 2'b10 : 2'b01;
   assign sel_rd     = win ? bus.m1_rd_i   : bus.m0_rd_i;
   assign sel_wr     = win ? bus.m1_wr_i   : bus.m0_wr_i;
   assign sel_addr   = win ? bus.m1_addr_i : bus.m0_addr_i;
   assign sel_wdata  = win ? bus.m1_data_i : bus.m0_data_i;
   assign sel_bsel   = win ? bus.m1_bsel_i : bus.m0_bsel_i;

   assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

   // Next-state and registered-output logic of the IDLE/BUSY/RESP sequencer.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      mem_rd_d     = mem_rd_q;
      mem_wr_d     = mem_wr_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_bsel_d   = mem_bsel_q;
      rsp_ready_d  = 2'b00;
      rsp_err_d    = 1'b0;
      rsp_data_d   = '0;

      unique case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               grant_d      = win_onehot;
               last_grant_d = win;
               cnt_d        = '0;
               if (sel_rd && sel_wr) begin
                  // Illegal request: answer at once, bus stays untouched.
                  rsp_ready_d = win_onehot;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = ERR_DATA;
                  state_d     = S_RESP;
               end else begin
                  mem_rd_d    = sel_rd;
                  mem_wr_d    = sel_wr;
                  mem_addr_d  = sel_addr;
                  mem_wdata_d = sel_wdata;
                  mem_bsel_d  = sel_bsel;
                  state_d     = S_BUSY;
               end
            end
         end

         S_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            // A memory answer in the timeout cycle still counts as success.
            if (bus.mem_ready_i) begin
               mem_rd_d    = 1'b0;
               mem_wr_d    = 1'b0;
               rsp_ready_d = grant_q;
               rsp_data_d  = mem_rd_q ? bus.mem_data_i : ERR_DATA;
               state_d     = S_RESP;
            end else if (timeout_hit) begin
               mem_rd_d    = 1'b0;
               mem_wr_d    = 1'b0;
               rsp_ready_d = grant_q;
               rsp_err_d   = 1'b1;
               rsp_data_d  = ERR_DATA;
               state_d     = S_RESP;
            end
         end

         S_RESP: begin
            grant_d = 2'b00;
            state_d = S_IDLE;
         end

         default: begin
            grant_d  = 2'b00;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   // State and bus registers; reset drops any transaction in flight without a response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         grant_q      <= 2'b00;
         mem_rd_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_bsel_q   <= '0;
         rsp_ready_q  <= 2'b00;
         rsp_err_q    <= 1'b0;
         rsp_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         mem_rd_q     <= mem_rd_d;
         mem_wr_q     <= mem_wr_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_bsel_q   <= mem_bsel_d;
         rsp_ready_q  <= rsp_ready_d;
         rsp_err_q    <= rsp_err_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   assign bus.mem_rd_o   = mem_rd_q;
   assign bus.mem_wr_o   = mem_wr_q;
   assign bus.mem_addr_o = mem_addr_q;
   assign bus.mem_data_o = mem_wdata_q;
   assign bus.mem_bsel_o = mem_bsel_q;
   assign bus.grant_o    = grant_q;

   // Response is routed to the owner only; the other master sees zeros.
   assign bus.m0_ready_o = rsp_ready_q[0];
   assign bus.m0_err_o   = rsp_ready_q[0] & rsp_err_q;
   assign bus.m0_data_o  = rsp_ready_q[0] ? rsp_data_q : '0;
   assign bus.m1_ready_o = rsp_ready_q[1];
   assign bus.m1_err_o   = rsp_ready_q[1] & rsp_err_q;
   assign bus.m1_data_o  = rsp_ready_q[1] ? rsp_data_q : '0;

endmodule
